// File: rtl/seg_scan_controller_pkg.sv
// Purpose : shared types, constants and the hex -> 7-segment table for the display scan blocks.
// Latency : n/a (declarations only).
// Backpress: n/a.
package seg_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } state_t;

   localparam logic [7:0] SEG_OFF   = 8'hFF;
   localparam logic [3:0] ANODE_OFF = 4'hF;

   // Active-low gfedcba pattern for one hex nibble.
   function automatic logic [6:0] hex_to_seg7(input logic [3:0] nibble);
      logic [6:0] r_pat;
      case (nibble)
         4'h0:    r_pat = 7'h40;
         4'h1:    r_pat = 7'h79;
         4'h2:    r_pat = 7'h24;
         4'h3:    r_pat = 7'h30;
         4'h4:    r_pat = 7'h19;
         4'h5:    r_pat = 7'h12;
         4'h6:    r_pat = 7'h02;
         4'h7:    r_pat = 7'h78;
         4'h8:    r_pat = 7'h00;
         4'h9:    r_pat = 7'h10;
         4'hA:    r_pat = 7'h08;
         4'hB:    r_pat = 7'h03;
         4'hC:    r_pat = 7'h46;
         4'hD:    r_pat = 7'h21;
         4'hE:    r_pat = 7'h06;
         default: r_pat = 7'h0E;
      endcase
      return r_pat;
   endfunction

endpackage

// File: rtl/seg_scan_controller_if.sv
// Purpose : bundles the value handshake, live display controls and the 7-seg bus.
// Latency : n/a (wires only).
// Backpress: value_valid/value_ready; the producer holds value until accepted.
// Ports   : value/value_valid/value_ready, digit_en, dp, lz_blank, seg, anode, frame_done.
interface seg_scan_controller_if;
   logic [15:0] value;
   logic        value_valid;
   logic        value_ready;
   logic [3:0]  digit_en;
   logic [3:0]  dp;
   logic        lz_blank;
   logic [7:0]  seg;
   logic [3:0]  anode;
   logic        frame_done;

   // Producer / board side.
   modport master (
      output value, value_valid, digit_en, dp, lz_blank,
      input  value_ready, seg, anode, frame_done
   );

   // Scan controller side.
   modport slave (
      input  value, value_valid, digit_en, dp, lz_blank,
      output value_ready, seg, anode, frame_done
   );
endinterface

// File: rtl/seg_scan_controller_seg7_decoder.sv
// Purpose : combinational hex nibble -> active-low gfedcba segment pattern.
// Latency : 0 cycles (pure combinational).
// Backpress: none.
// Ports   : i_nibble (4) in, o_seg (7) out.
module seg7_decoder
   import seg_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);
   assign o_seg = hex_to_seg7(i_nibble);
endmodule

// File: rtl/seg_scan_controller.sv
// Purpose : scans four hex digits onto a shared 7-seg bus with a dark gap before each digit.
// Latency : seg/anode registered from next-state, so they change on the edge entering their slot.
// Backpress: value_ready is high only in the first cycle of each frame; value is shadowed there.
// Ports   : clk, reset (sync, active-high), bus (slave modport of seg_scan_controller_if).
module seg_scan_controller
   import seg_pkg::*;
#(
   parameter int ON_CYCLES    = 4096,
   parameter int BLANK_CYCLES = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   seg_scan_controller_if.slave  bus
);
   localparam int MAX_CYC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [1:0]       r_idx, w_idx_nxt;
   logic [15:0]      r_shadow, w_shadow_nxt;
   logic [7:0]       r_seg, w_seg_nxt;
   logic [3:0]       r_anode, w_anode_nxt;
   logic             r_frame_done;
   logic             w_ready, w_accept, w_last_show;
   logic [3:0]       w_nibble;
   logic [6:0]       w_seg7;
   logic             w_upper_zero, w_dark;

   // Frame start is the single cycle BLANK/idx 0/cnt 0.
   assign w_ready      = !reset && (r_state == BLANK) && (r_idx == 2'd0) && (r_cnt == '0);
   assign w_accept     = w_ready && bus.value_valid;
   assign w_shadow_nxt = w_accept ? bus.value : r_shadow;
   assign w_last_show  = (r_state == SHOW) && (r_idx == 2'd3) && (r_cnt == ON_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= BLANK;
         r_cnt    <= '0;
         r_idx    <= 2'd0;
         r_shadow <= 16'h0000;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_idx    <= w_idx_nxt;
         r_shadow <= w_shadow_nxt;
      end
   end

   // Next-state logic: cnt restarts at every phase change, idx advances after each lit slot.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_idx_nxt   = r_idx;
      case (r_state)
         BLANK: begin
            if (r_cnt == BLANK_LAST) begin
               w_state_nxt = SHOW;
               w_cnt_nxt   = '0;
            end
         end
         SHOW: begin
            if (r_cnt == ON_LAST) begin
               w_state_nxt = BLANK;
               w_cnt_nxt   = '0;
               w_idx_nxt   = r_idx + 2'd1;
            end
         end
         default: begin
            w_state_nxt = BLANK;
            w_cnt_nxt   = '0;
            w_idx_nxt   = 2'd0;
         end
      endcase
   end

   // Outputs are computed for the state being entered, using the shadow as it will be
   // after this edge so a single-cycle blank still shows the freshly accepted value.
   assign w_nibble     = w_shadow_nxt[{w_idx_nxt, 2'b00} +: 4];
   assign w_upper_zero = (w_shadow_nxt >> {w_idx_nxt, 2'b00}) == 16'h0000;
   assign w_dark       = !bus.digit_en[w_idx_nxt] ||
                         (bus.lz_blank && (w_idx_nxt != 2'd0) && w_upper_zero);

   seg7_decoder u_dec (
      .i_nibble (w_nibble),
      .o_seg    (w_seg7)
   );

   // Output logic.
   always_comb begin
      w_seg_nxt   = SEG_OFF;
      w_anode_nxt = ANODE_OFF;
      if ((w_state_nxt == SHOW) && !w_dark) begin
         w_anode_nxt = ~(4'b0001 << w_idx_nxt);
         w_seg_nxt   = {~bus.dp[w_idx_nxt], w_seg7};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_seg        <= SEG_OFF;
         r_anode      <= ANODE_OFF;
         r_frame_done <= 1'b0;
      end else begin
         r_seg        <= w_seg_nxt;
         r_anode      <= w_anode_nxt;
         r_frame_done <= w_last_show;
      end
   end

   assign bus.value_ready = w_ready;
   assign bus.seg         = r_seg;
   assign bus.anode       = r_anode;
   assign bus.frame_done  = r_frame_done;
endmodule

// File: tb/tb_seg_scan_controller.sv
// Purpose : self-checking bench for seg_scan_controller with ON_CYCLES=4, BLANK_CYCLES=2.
// Latency : reference model predicts every cycle from frame position and previous-cycle inputs.
// Backpress: producer holds value_valid/value until the frame-start acceptance.
module tb_seg_scan_controller;
   localparam int ON    = 4;
   localparam int BL    = 2;
   localparam int SLOT  = ON + BL;
   localparam int FRAME = 4 * SLOT;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   seg_scan_controller_if bus ();

   seg_scan_controller #(.ON_CYCLES(ON), .BLANK_CYCLES(BL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [15:0]     value;
      logic [3:0]      en;
      logic [3:0]      dp;
      logic            lz;
      logic [3:0][7:0] seg;   // expected seg per digit, [3] = digit 3
      logic [3:0][3:0] an;
   } vec_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          m_t;
   logic [15:0] m_shadow;
   logic [3:0]  p_en, p_dp;
   logic        p_lz;
   logic [7:0]  hexrom [16];
   bit          tbl_on = 0;
   logic [3:0][7:0] tbl_seg;
   logic [3:0][3:0] tbl_an;
   int          hand_t = -1;
   logic [7:0]  hand_seg;
   logic [3:0]  hand_an;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0d: got %0h expected %0h", name, m_t, act, exp);
      end
   endtask

   // One clock cycle: compare at negedge, then advance the model and return at posedge+1.
   task automatic step();
      logic [7:0] es;
      logic [3:0] ea;
      logic [3:0] nib;
      logic       hi_zero;
      int p, slot, w;
      @(negedge clk);
      p    = m_t % FRAME;
      slot = p / SLOT;
      w    = p % SLOT;
      es   = 8'hFF;
      ea   = 4'hF;
      if (w >= BL) begin
         nib     = m_shadow[4*slot +: 4];
         hi_zero = (m_shadow >> (4*slot)) == 16'h0000;
         if (p_en[slot] && !(p_lz && slot > 0 && hi_zero)) begin
            ea = ~(4'b0001 << slot);
            es = {~p_dp[slot], hexrom[nib][6:0]};
         end
      end
      check("seg", bus.seg, es);
      check("anode", bus.anode, ea);
      check("ready", bus.value_ready, p == 0);
      check("frame_done", bus.frame_done, (p == 0) && (m_t > 0));
      if (tbl_on && w == BL + 1) begin
         check("tbl_seg", bus.seg, tbl_seg[slot]);
         check("tbl_anode", bus.anode, tbl_an[slot]);
      end
      if (m_t == hand_t) begin
         check("hand_seg", bus.seg, hand_seg);
         check("hand_anode", bus.anode, hand_an);
      end
      if (bus.value_valid && p == 0) m_shadow = bus.value;
      p_en = bus.digit_en;
      p_dp = bus.dp;
      p_lz = bus.lz_blank;
      m_t++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_ready", bus.value_ready, 1'b0);
      check("rst_seg", bus.seg, 8'hFF);
      check("rst_anode", bus.anode, 4'hF);
      check("rst_frame_done", bus.frame_done, 1'b0);
      @(posedge clk);
      #1;
      reset    = 1'b0;
      m_t      = 0;
      m_shadow = 16'h0000;
      p_en     = bus.digit_en;
      p_dp     = bus.dp;
      p_lz     = bus.lz_blank;
   endtask

   function automatic logic [15:0] rand_value();
      logic [15:0] v;
      logic [15:0] m;
      int k;
      v = 16'($urandom);
      k = $urandom_range(0, 4);
      m = 16'hFFFF;
      m = m >> (4 * (4 - k));
      return v & m;
   endfunction

   vec_t vecs [7];
   bit   acc;

   initial begin
      hexrom = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
      vecs[0] = '{16'h1234, 4'hF, 4'h0, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99}, {4'h7, 4'hB, 4'hD, 4'hE}};
      vecs[1] = '{16'h0050, 4'hF, 4'h0, 1'b1, {8'hFF, 8'hFF, 8'h92, 8'hC0}, {4'hF, 4'hF, 4'hD, 4'hE}};
      vecs[2] = '{16'h0000, 4'hF, 4'h0, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}, {4'hF, 4'hF, 4'hF, 4'hE}};
      vecs[3] = '{16'h8888, 4'b0101, 4'b0001, 1'b0, {8'hFF, 8'h80, 8'hFF, 8'h00}, {4'hF, 4'hB, 4'hF, 4'hE}};
      vecs[4] = '{16'hABCD, 4'hF, 4'hF, 1'b0, {8'h08, 8'h03, 8'h46, 8'h21}, {4'h7, 4'hB, 4'hD, 4'hE}};
      vecs[5] = '{16'h0F00, 4'hF, 4'b0100, 1'b1, {8'hFF, 8'h0E, 8'hC0, 8'hC0}, {4'hF, 4'hB, 4'hD, 4'hE}};
      vecs[6] = '{16'h0000, 4'hF, 4'h0, 1'b0, {8'hC0, 8'hC0, 8'hC0, 8'hC0}, {4'h7, 4'hB, 4'hD, 4'hE}};

      bus.value       = 16'h0000;
      bus.value_valid = 1'b0;
      bus.digit_en    = 4'hF;
      bus.dp          = 4'h0;
      bus.lz_blank    = 1'b0;
      reset           = 1'b1;
      #1;
      do_reset();

      // Idle frame after reset: digit 0 shows 0 in cycles 2-5, frame_done first at cycle 24.
      hand_t = 2; hand_seg = 8'hC0; hand_an = 4'hE;
      for (int c = 0; c < FRAME; c++) step();

      // Table vectors: each accepted at a frame start and displayed for the whole frame.
      for (int i = 0; i < 7; i++) begin
         bus.value       = vecs[i].value;
         bus.digit_en    = vecs[i].en;
         bus.dp          = vecs[i].dp;
         bus.lz_blank    = vecs[i].lz;
         bus.value_valid = 1'b1;
         step();
         bus.value_valid = 1'b0;
         tbl_seg = vecs[i].seg;
         tbl_an  = vecs[i].an;
         tbl_on  = 1;
         for (int c = 1; c < FRAME; c++) step();
         tbl_on = 0;
      end

      // Late valid: raised mid-frame, only taken at the next frame start.
      bus.digit_en = 4'hF; bus.dp = 4'h0; bus.lz_blank = 1'b0;
      bus.value = 16'h1234; bus.value_valid = 1'b1;
      step();
      bus.value_valid = 1'b0;
      for (int c = 1; c < 10; c++) step();
      bus.value = 16'hABCD; bus.value_valid = 1'b1;
      hand_t = m_t + 16; hand_seg = 8'hA1; hand_an = 4'hE;
      for (int c = 10; c < FRAME; c++) step();
      step();
      bus.value_valid = 1'b0;
      for (int c = 1; c < FRAME; c++) step();

      // Randomized traffic against the model.
      for (int c = 0; c < 8 * FRAME; c++) begin
         bus.digit_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
         bus.dp       = 4'($urandom);
         bus.lz_blank = 1'($urandom_range(0, 1));
         if (!bus.value_valid && $urandom_range(0, 3) == 0) begin
            bus.value       = rand_value();
            bus.value_valid = 1'b1;
         end
         acc = bus.value_valid && (m_t % FRAME == 0);
         step();
         if (acc) bus.value_valid = 1'b0;
      end
      while (m_t % FRAME != 0) step();

      // Reset during the digit-2 lit slot with a handshake pending.
      bus.digit_en = 4'hF; bus.dp = 4'h0; bus.lz_blank = 1'b0;
      bus.value = 16'h1234; bus.value_valid = 1'b1;
      step();
      bus.value = 16'h5678;
      for (int c = 1; c < 15; c++) step();
      reset = 1'b1;
      @(negedge clk);
      check("midrst_ready_now", bus.value_ready, 1'b0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("midrst_seg", bus.seg, 8'hFF);
      check("midrst_anode", bus.anode, 4'hF);
      check("midrst_ready", bus.value_ready, 1'b0);
      check("midrst_frame_done", bus.frame_done, 1'b0);
      @(posedge clk);
      #1;
      reset           = 1'b0;
      bus.value_valid = 1'b0;
      m_t      = 0;
      m_shadow = 16'h0000;
      p_en = bus.digit_en; p_dp = bus.dp; p_lz = bus.lz_blank;
      hand_t = 2; hand_seg = 8'hC0; hand_an = 4'hE;
      for (int c = 0; c < FRAME + 1; c++) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
